// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared constants for the multicycle controller:
// opcodes, functs, state codes and datapath mux selects.
package mc_ctrl_fsm_pkg;

  localparam logic [5:0] OP_R      = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JUMP_REG = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    OC_R, OC_RJ, OC_I, OC_LOAD,
    OC_STORE, OC_BR, OC_J, OC_ILL
  } op_class_e;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS   = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;
  localparam logic [1:0] PCS_BR    = 2'b01;
  localparam logic [1:0] PCS_JUMP  = 2'b10;
  localparam logic [1:0] PCS_REG   = 2'b11;
  localparam logic [1:0] M2R_MEM   = 2'b01;
  localparam logic [1:0] M2R_PC    = 2'b10;
  localparam logic [1:0] RDST_RT   = 2'b00;
  localparam logic [1:0] RDST_RD   = 2'b01;
  localparam logic [1:0] RDST_RA   = 2'b10;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal_op;
    logic [1:0] pc_source;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Instruction/memory inputs and datapath
// controls of the multicycle controller.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write_cond;
  logic       pc_write;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       illegal_op;
  logic [1:0] pc_source;
  logic [1:0] mem_to_reg;
  logic [1:0] reg_dst;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_ctrl_op;
  logic [3:0] state;

  modport master (
    output op, funct, mem_ready,
    input  pc_write_cond, pc_write, mem_read,
    input  mem_write, ir_write, reg_write,
    input  illegal_op, pc_source, mem_to_reg,
    input  reg_dst, alu_src_a, alu_src_b,
    input  alu_ctrl_op, state
  );

  modport slave (
    input  op, funct, mem_ready,
    output pc_write_cond, pc_write, mem_read,
    output mem_write, ir_write, reg_write,
    output illegal_op, pc_source, mem_to_reg,
    output reg_dst, alu_src_a, alu_src_b,
    output alu_ctrl_op, state
  );
endinterface

// File: rtl/mc_op_class.sv
// Opcode classifier: maps op/funct to the
// instruction class that steers DECODE.
module mc_op_class
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output op_class_e  class_o
);

  // Pure lookup; unknown opcodes fall to OC_ILL
  always_comb begin
    class_o = OC_ILL;
    case (op_i)
      OP_R: begin
        if (funct_i == FN_JR || funct_i == FN_JALR)
          class_o = OC_RJ;
        else
          class_o = OC_R;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
      OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU:
        class_o = OC_I;
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW:
        class_o = OC_LOAD;
      OP_SB, OP_SH, OP_SW:
        class_o = OC_STORE;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM:
        class_o = OC_BR;
      OP_J, OP_JAL:
        class_o = OC_J;
      default:
        class_o = OC_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-style control FSM: state register
// plus state/op decode into datapath strobes and selects.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned USE_READY = 1
) (
  input logic          clk,
  input logic          rst_n,
  mc_ctrl_fsm_if.slave bus
);

  state_e    state_q, state_d;
  op_class_e cls;
  ctrl_t     c_d, c;
  logic      g;

  assign g = (USE_READY != 0) ? bus.mem_ready : 1'b1;

  mc_op_class u_op_class (
    .op_i    (bus.op),
    .funct_i (bus.funct),
    .class_o (cls)
  );

  // State register; only storage in the block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d = S_FETCH;
    c_d     = '0;
    case (state_q)
      S_FETCH: begin
        c_d.mem_read  = 1'b1;
        c_d.alu_src_b = SRCB_FOUR;
        c_d.ir_write  = g;
        c_d.pc_write  = g;
        state_d = g ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        c_d.alu_src_b = SRCB_BOFF;
        case (cls)
          OC_RJ:    state_d = S_JUMP_REG;
          OC_R:     state_d = S_R_EXEC;
          OC_I:     state_d = S_I_EXEC;
          OC_LOAD:  state_d = S_MEM_ADDR;
          OC_STORE: state_d = S_MEM_ADDR;
          OC_BR:    state_d = S_BRANCH;
          OC_J:     state_d = S_JUMP;
          default:  state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        c_d.alu_src_a = SRCA_RS;
        c_d.alu_src_b = SRCB_IMM;
        state_d = (cls == OC_STORE) ? S_MEM_WR
                                    : S_MEM_RD;
      end
      S_MEM_RD: begin
        c_d.mem_read  = 1'b1;
        c_d.alu_src_a = SRCA_RS;
        c_d.alu_src_b = SRCB_IMM;
        state_d = g ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        c_d.reg_write  = 1'b1;
        c_d.mem_to_reg = M2R_MEM;
        c_d.reg_dst    = RDST_RT;
      end
      S_MEM_WR: begin
        c_d.mem_write = 1'b1;
        c_d.alu_src_a = SRCA_RS;
        c_d.alu_src_b = SRCB_IMM;
        state_d = g ? S_FETCH : S_MEM_WR;
      end
      S_R_EXEC: begin
        c_d.alu_src_a   = SRCA_RS;
        c_d.alu_ctrl_op = ALU_FUNCT;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        c_d.reg_write = 1'b1;
        c_d.reg_dst   = RDST_RD;
      end
      S_BRANCH: begin
        c_d.alu_src_a     = SRCA_RS;
        c_d.alu_ctrl_op   = ALU_SUB;
        c_d.pc_source     = PCS_BR;
        c_d.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        c_d.pc_source = PCS_JUMP;
        c_d.pc_write  = 1'b1;
        if (bus.op == OP_JAL) begin
          c_d.reg_write  = 1'b1;
          c_d.reg_dst    = RDST_RA;
          c_d.mem_to_reg = M2R_PC;
        end
      end
      S_I_EXEC: begin
        c_d.alu_src_a   = SRCA_RS;
        c_d.alu_src_b   = SRCB_IMM;
        c_d.alu_ctrl_op = ALU_IMM;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        c_d.reg_write = 1'b1;
        c_d.reg_dst   = RDST_RT;
      end
      S_JUMP_REG: begin
        c_d.pc_source = PCS_REG;
        c_d.pc_write  = 1'b1;
        if (bus.funct == FN_JALR) begin
          c_d.reg_write  = 1'b1;
          c_d.reg_dst    = RDST_RD;
          c_d.mem_to_reg = M2R_PC;
        end
      end
      S_ILLEGAL: begin
        c_d.illegal_op = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset kills every strobe at once, even mid-cycle
  assign c = rst_n ? c_d : '0;

  assign bus.pc_write_cond = c.pc_write_cond;
  assign bus.pc_write      = c.pc_write;
  assign bus.mem_read      = c.mem_read;
  assign bus.mem_write     = c.mem_write;
  assign bus.ir_write      = c.ir_write;
  assign bus.reg_write     = c.reg_write;
  assign bus.illegal_op    = c.illegal_op;
  assign bus.pc_source     = c.pc_source;
  assign bus.mem_to_reg    = c.mem_to_reg;
  assign bus.reg_dst       = c.reg_dst;
  assign bus.alu_src_a     = c.alu_src_a;
  assign bus.alu_src_b     = c.alu_src_b;
  assign bus.alu_ctrl_op   = c.alu_ctrl_op;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench: per-instruction phase sequences
// predict every cycle of two controller instances.
module tb_mc_ctrl_fsm;

  typedef enum int {
    P_F, P_D, P_MA, P_MRD, P_MWB, P_MWR, P_RX,
    P_AWB, P_BR, P_J, P_IX, P_IWB, P_JR, P_ILL
  } ph_t;

  typedef struct packed {
    logic [3:0] st;
    logic       pwc, pw, mr, mw, irw, rw, ill;
    logic [1:0] pcs, m2r, rdst, asa, asb, aop;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nchecks = 0;
  int   nerr = 0;
  obs_t q1[$];
  obs_t q0[$];

  logic [5:0] legal[24] = '{
    6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
    6'h06, 6'h07, 6'h08, 6'h09, 6'h0a, 6'h0b,
    6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21,
    6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b
  };

  always #5 clk = ~clk;

  mc_ctrl_fsm_if bus1 ();
  mc_ctrl_fsm_if bus0 ();

  mc_ctrl_fsm #(.USE_READY(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  mc_ctrl_fsm #(.USE_READY(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  function automatic obs_t snap(input int d);
    obs_t o;
    if (d == 1) begin
      o = '{bus1.state, bus1.pc_write_cond,
            bus1.pc_write, bus1.mem_read,
            bus1.mem_write, bus1.ir_write,
            bus1.reg_write, bus1.illegal_op,
            bus1.pc_source, bus1.mem_to_reg,
            bus1.reg_dst, bus1.alu_src_a,
            bus1.alu_src_b, bus1.alu_ctrl_op};
    end else begin
      o = '{bus0.state, bus0.pc_write_cond,
            bus0.pc_write, bus0.mem_read,
            bus0.mem_write, bus0.ir_write,
            bus0.reg_write, bus0.illegal_op,
            bus0.pc_source, bus0.mem_to_reg,
            bus0.reg_dst, bus0.alu_src_a,
            bus0.alu_src_b, bus0.alu_ctrl_op};
    end
    return o;
  endfunction

  task automatic cmp(input string nm,
                     input obs_t got, input obs_t exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got st=%0d o=%h want st=%0d o=%h",
               nm, $time, got.st, got[18:0],
               exp.st, exp[18:0]);
    end
  endtask

  // Expected controls for one cycle of a phase
  function automatic obs_t exp_of(input ph_t p,
      input logic [5:0] op, input logic [5:0] fn,
      input logic g);
    obs_t e = '0;
    case (p)
      P_F: begin
        e.st = 0; e.mr = 1; e.asb = 2'b01;
        e.irw = g; e.pw = g;
      end
      P_D:   begin e.st = 1; e.asb = 2'b11; end
      P_MA:  begin e.st = 2; e.asa = 1; e.asb = 2; end
      P_MRD: begin
        e.st = 3; e.mr = 1; e.asa = 1; e.asb = 2;
      end
      P_MWB: begin e.st = 4; e.rw = 1; e.m2r = 1; end
      P_MWR: begin
        e.st = 5; e.mw = 1; e.asa = 1; e.asb = 2;
      end
      P_RX:  begin e.st = 6; e.asa = 1; e.aop = 2; end
      P_AWB: begin e.st = 7; e.rw = 1; e.rdst = 1; end
      P_BR: begin
        e.st = 8; e.asa = 1; e.aop = 1;
        e.pcs = 1; e.pwc = 1;
      end
      P_J: begin
        e.st = 9; e.pcs = 2; e.pw = 1;
        if (op == 6'h03) begin
          e.rw = 1; e.rdst = 2; e.m2r = 2;
        end
      end
      P_IX: begin
        e.st = 10; e.asa = 1; e.asb = 2; e.aop = 3;
      end
      P_IWB: begin e.st = 11; e.rw = 1; end
      P_JR: begin
        e.st = 12; e.pcs = 3; e.pw = 1;
        if (fn == 6'h09) begin
          e.rw = 1; e.rdst = 1; e.m2r = 2;
        end
      end
      default: begin e.st = 13; e.ill = 1; end
    endcase
    return e;
  endfunction

  // stall: -1 random ready, -2 ready tied low,
  // n>=0 ready high except n low cycles in MEM_RD
  task automatic run(input int d, input logic [5:0] op,
                     input logic [5:0] fn, input int stall);
    ph_t  s[$];
    int   i = 0;
    int   st = stall;
    int   cyc = 0;
    logic mr, g;
    s.push_back(P_F);
    s.push_back(P_D);
    if (op == 6'h00) begin
      if (fn == 6'h08 || fn == 6'h09) s.push_back(P_JR);
      else begin s.push_back(P_RX); s.push_back(P_AWB); end
    end else if (op inside {[6'h08:6'h0f]}) begin
      s.push_back(P_IX); s.push_back(P_IWB);
    end else if (op inside {6'h20, 6'h21, 6'h23,
                            6'h24, 6'h25}) begin
      s.push_back(P_MA); s.push_back(P_MRD);
      s.push_back(P_MWB);
    end else if (op inside {6'h28, 6'h29, 6'h2b}) begin
      s.push_back(P_MA); s.push_back(P_MWR);
    end else if (op inside {[6'h01:6'h01],
                            [6'h04:6'h07]}) begin
      s.push_back(P_BR);
    end else if (op == 6'h02 || op == 6'h03) begin
      s.push_back(P_J);
    end else begin
      s.push_back(P_ILL);
    end
    while (i < s.size()) begin
      if (stall == -1)
        mr = (cyc > 16) ? 1'b1 : ($urandom_range(0, 3) != 0);
      else if (stall == -2)
        mr = 1'b0;
      else if (s[i] == P_MRD && st > 0) begin
        mr = 1'b0; st--;
      end else
        mr = 1'b1;
      g = (d == 1) ? mr : 1'b1;
      if (d == 1) begin
        bus1.op = op; bus1.funct = fn; bus1.mem_ready = mr;
        q1.push_back(exp_of(s[i], op, fn, g));
      end else begin
        bus0.op = op; bus0.funct = fn; bus0.mem_ready = mr;
        q0.push_back(exp_of(s[i], op, fn, g));
      end
      @(posedge clk); #1;
      cyc++;
      if (!((s[i] == P_F || s[i] == P_MRD ||
             s[i] == P_MWR) && !g))
        i++;
    end
  endtask

  task automatic run_rand(input int d, input int n);
    logic [5:0] op, fn;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0)
        op = 6'($urandom_range(0, 63));
      else
        op = legal[$urandom_range(0, 23)];
      fn = 6'($urandom_range(0, 63));
      if (op == 6'h00 && $urandom_range(0, 2) == 0)
        fn = ($urandom_range(0, 1) == 1) ? 6'h09 : 6'h08;
      run(d, op, fn, -1);
    end
  endtask

  // Monitor: one prediction consumed per cycle
  always @(negedge clk) begin
    if (rst_n && q1.size() != 0)
      cmp("dut1_cycle", snap(1), q1.pop_front());
    if (rst_n && q0.size() != 0)
      cmp("dut0_cycle", snap(0), q0.pop_front());
  end

  initial begin
    obs_t e;
    rst_n = 1'b0;
    bus1.op = 6'h00; bus1.funct = 6'h20;
    bus1.mem_ready = 1'b1;
    bus0.op = 6'h00; bus0.funct = 6'h20;
    bus0.mem_ready = 1'b1;
    #3;
    cmp("reset_dut1", snap(1), '0);
    cmp("reset_dut0", snap(0), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fork
      begin
        run(1, 6'h00, 6'h20, 0);
        run(1, 6'h23, 6'h00, 2);
        run(1, 6'h03, 6'h00, 0);
        run(1, 6'h3f, 6'h00, 0);
        run(1, 6'h2b, 6'h00, 0);
        run(1, 6'h00, 6'h09, 0);
        run_rand(1, 40);
      end
      begin
        run(0, 6'h08, 6'h00, -2);
        run(0, 6'h23, 6'h00, -2);
        run(0, 6'h2b, 6'h00, -2);
        run_rand(0, 40);
      end
    join
    // Abort a store stuck in MEM_WR with async reset
    bus1.op = 6'h2b; bus1.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus1.mem_ready = 1'b0;
    e = '0;
    e.st = 5; e.mw = 1; e.asa = 1; e.asb = 2;
    cmp("sw_mem_wr", snap(1), e);
    @(posedge clk); #1;
    cmp("sw_mem_wr_hold", snap(1), e);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_dut1", snap(1), '0);
    cmp("async_rst_dut0", snap(0), '0);
    @(posedge clk); #1;
    cmp("rst_held_dut1", snap(1), '0);
    rst_n = 1'b1;
    fork
      run(1, 6'h23, 6'h00, 1);
      run(0, 6'h00, 6'h08, -2);
    join
    @(negedge clk);
    if (q1.size() != 0 || q0.size() != 0) begin
      nchecks++; nerr++;
      $display("FAIL drain: q1=%0d q0=%0d left",
               q1.size(), q0.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end

endmodule
